load_unit: RTL and testbench

LOAD_UNIT -- requirements
Module: load_unit

---
 rtl/load_unit_pkg.sv | 39 +++
 rtl/load_extender.sv | 34 +++
 rtl/load_unit.sv | 132 +++++++++++++
 tb/tb_load_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/load_unit_pkg.sv
// Shared memory-operation definitions for the load/store datapath.
// - load_kind_e : load-kind encoding carried on the 3-bit control bus
// - store_kind_e: store-splice codes used by the store path
// - load_ok()   : legality + natural-alignment test for a load request
package load_unit_pkg;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LD  = 3'b011,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101,
    LD_LWU = 3'b110,
    LD_ILL = 3'b111
  } load_kind_e;

  typedef enum logic [1:0] {
    ST_SB = 2'b00,
    ST_SH = 2'b01,
    ST_SW = 2'b10,
    ST_SD = 2'b11
  } store_kind_e;

  // True when the kind is legal and the byte offset is naturally aligned.
  function automatic logic load_ok(input logic [2:0] kind, input logic [2:0] off);
    logic ok;
    ok = 1'b0;
    case (load_kind_e'(kind))
      LD_LB, LD_LBU: ok = 1'b1;
      LD_LH, LD_LHU: ok = (off[0] == 1'b0);
      LD_LW, LD_LWU: ok = (off[1:0] == 2'b00);
      LD_LD:         ok = (off == 3'b000);
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_extender.sv
// Combinational lane select and sign/zero extension for loads.
// Ports:
//   control  [2:0]  load kind (load_kind_e encoding)
//   offset   [2:0]  byte offset of the load within the doubleword
//   rdata    [63:0] little-endian doubleword from memory
//   extended [63:0] selected lane, extended to 64 bits (0 for illegal kind)
module load_extender
  import load_unit_pkg::*;
(
  input  logic [2:0]  control,
  input  logic [2:0]  offset,
  input  logic [63:0] rdata,
  output logic [63:0] extended
);

  logic [63:0] w_shift;

  assign w_shift = rdata >> {offset, 3'b000};

  always_comb begin
    extended = '0;
    case (load_kind_e'(control))
      LD_LB:   extended = {{56{w_shift[7]}},  w_shift[7:0]};
      LD_LH:   extended = {{48{w_shift[15]}}, w_shift[15:0]};
      LD_LW:   extended = {{32{w_shift[31]}}, w_shift[31:0]};
      LD_LD:   extended = w_shift;
      LD_LBU:  extended = {56'd0, w_shift[7:0]};
      LD_LHU:  extended = {48'd0, w_shift[15:0]};
      LD_LWU:  extended = {32'd0, w_shift[31:0]};
      default: extended = '0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Load unit: issues one doubleword read per load, waits for mem_ack with a
// bounded timeout, then returns the lane-selected, extended result.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             load request (only accepted in IDLE)
//   control [2:0]     load kind
//   addr [63:0]       byte address
//   mem_req           read request, held for the whole WAIT phase
//   mem_addr [63:0]   doubleword-aligned request address
//   mem_ack           read data valid (only honoured in WAIT)
//   mem_rdata [63:0]  read data
//   busy              high in WAIT and DONE
//   done              one-cycle completion pulse
//   fault             qualifies done: misaligned, illegal or timed out
//   o_data [63:0]     load result, held until the next done
module load_unit
  import load_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  control,
  input  logic [63:0] addr,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [63:0] o_data
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e      r_state;
  logic [2:0]  r_ctrl;
  logic [2:0]  r_off;
  logic [CW-1:0] r_cnt;
  logic        r_mem_req;
  logic [63:0] r_mem_addr;
  logic        r_busy;
  logic        r_done;
  logic        r_fault;
  logic [63:0] r_data;
  logic [63:0] w_ext;

  load_extender u_ext (
    .control  (r_ctrl),
    .offset   (r_off),
    .rdata    (mem_rdata),
    .extended (w_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ctrl     <= '0;
      r_off      <= '0;
      r_cnt      <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fault    <= 1'b0;
      r_data     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (load_ok(control, addr[2:0])) begin
              r_ctrl     <= control;
              r_off      <= addr[2:0];
              r_mem_addr <= {addr[63:3], 3'b000};
              r_cnt      <= '0;
              r_mem_req  <= 1'b1;
              r_state    <= S_WAIT;
            end else begin
              // Rejected requests never touch memory.
              r_done  <= 1'b1;
              r_fault <= 1'b1;
              r_data  <= '0;
              r_state <= S_DONE;
            end
          end
        end
        S_WAIT: begin
          // Ack is tested before the timeout so a last-cycle ack still succeeds.
          if (mem_ack) begin
            r_data    <= w_ext;
            r_fault   <= 1'b0;
            r_done    <= 1'b1;
            r_mem_req <= 1'b0;
            r_state   <= S_DONE;
          end else if (r_cnt == CW'(TIMEOUT)) begin
            r_data    <= '0;
            r_fault   <= 1'b1;
            r_done    <= 1'b1;
            r_mem_req <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_fault <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign busy     = r_busy;
  assign done     = r_done;
  assign fault    = r_fault;
  assign o_data   = r_data;

endmodule

// File: tb/tb_load_unit.sv
// Randomized self-checking bench for load_unit against an arithmetic
// reference model of the load semantics.
module tb_load_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  control;
  logic [63:0] addr;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [63:0] o_data;

  int n_checks = 0;
  int n_errors = 0;

  load_unit #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .control   (control),
    .addr      (addr),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .o_data    (o_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: size in bytes, signedness, alignment and value from arithmetic.
  function automatic logic [63:0] ref_load(input int kind, input logic [63:0] a,
                                           input logic [63:0] d, output bit legal);
    int size;
    bit sgn;
    logic [63:0] mask;
    logic [63:0] val;
    case (kind)
      0: begin size = 1; sgn = 1; end
      1: begin size = 2; sgn = 1; end
      2: begin size = 4; sgn = 1; end
      3: begin size = 8; sgn = 0; end
      4: begin size = 1; sgn = 0; end
      5: begin size = 2; sgn = 0; end
      6: begin size = 4; sgn = 0; end
      default: begin size = 0; sgn = 0; end
    endcase
    if (size == 0) begin
      legal = 0;
      return 64'd0;
    end
    legal = ((a % size) == 0);
    val = d >> (8 * (a % 8));
    if (size < 8) begin
      mask = (64'd1 << (8 * size)) - 64'd1;
      val = val & mask;
      if (sgn && val[8*size-1]) val = val | ~mask;
    end
    return val;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One load transaction. ack_dly = index of the WAIT cycle carrying mem_ack;
  // values above TMO mean no ack is ever given.
  task automatic run_load(input logic [2:0] k, input logic [63:0] a,
                          input logic [63:0] d, input int ack_dly);
    logic [63:0] exp_d;
    bit legal;
    bit exp_f;
    int exp_w;
    int waits;
    bit got;
    exp_d = ref_load(int'(k), a, d, legal);
    exp_f = !legal || (ack_dly > TMO);
    exp_w = !legal ? 0 : (exp_f ? TMO + 1 : ack_dly + 1);
    if (exp_f) exp_d = 64'd0;

    start = 1'b1; control = k; addr = a; mem_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    waits = 0;
    got = 0;
    for (int c = 0; c < TMO + 8 && !got; c++) begin
      if (done) begin
        got = 1;
        check("fault", 64'(fault), 64'(exp_f));
        check("data", o_data, exp_d);
        check("wait_cycles", 64'(waits), 64'(exp_w));
        check("busy_in_done", 64'(busy), 64'd1);
        check("req_in_done", 64'(mem_req), 64'd0);
        // start and a late ack while in DONE must both be ignored
        start = 1'b1; control = 3'($urandom); addr = rnd64(); mem_ack = 1'b1;
      end else if (mem_req) begin
        check("mem_addr", mem_addr, {a[63:3], 3'b000});
        check("busy_in_wait", 64'(busy), 64'd1);
        mem_ack = (waits == ack_dly);
        mem_rdata = mem_ack ? d : rnd64();
        waits++;
        // stray start during WAIT with different operands
        start = 1'($urandom_range(0, 1)); control = 3'($urandom); addr = rnd64();
      end else begin
        check("progress", {62'd0, done, mem_req}, legal ? 64'd1 : 64'd2);
      end
      @(negedge clk);
    end
    check("done_seen", 64'(got), 64'd1);
    start = 1'b0; mem_ack = 1'b0;
    check("done_pulse", 64'(done), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    check("req_idle", 64'(mem_req), 64'd0);
    check("hold", o_data, exp_d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] k;
    logic [63:0] a;
    int sz;
    reset = 1'b1; start = 1'b0; control = '0; addr = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_data", o_data, 64'd0);
    check("rst_addr", mem_addr, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    run_load(3'b000, 64'h1003, 64'h00000000_80000000, 2);
    check("lb_neg", o_data, 64'hFFFFFFFF_FFFFFF80);
    run_load(3'b101, 64'h2006, 64'hBEEF0000_00000000, 0);
    check("lhu_top", o_data, 64'h00000000_0000BEEF);
    run_load(3'b010, 64'h3002, rnd64(), 0);
    run_load(3'b111, 64'h3000, rnd64(), 0);
    run_load(3'b011, 64'h4000, rnd64(), 99);   // timeout
    run_load(3'b011, 64'h4008, 64'h01234567_89ABCDEF, TMO);  // ack on last cycle
    check("ld_last", o_data, 64'h01234567_89ABCDEF);

    // Reset in the middle of WAIT, followed by a late ack
    start = 1'b1; control = 3'b011; addr = 64'h5000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_req", 64'(mem_req), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_wait_req", 64'(mem_req), 64'd0);
    check("rst_wait_busy", 64'(busy), 64'd0);
    check("rst_wait_addr", mem_addr, 64'd0);
    mem_ack = 1'b1; mem_rdata = rnd64();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_ack_done", 64'(done), 64'd0);
      check("late_ack_req", 64'(mem_req), 64'd0);
    end
    mem_ack = 1'b0;
    run_load(3'b110, 64'h6004, 64'h87654321_00000000, 1);

    // Randomized loads
    for (int n = 0; n < 80; n++) begin
      k = 3'($urandom_range(0, 7));
      a = rnd64();
      sz = (k == 3'd3) ? 8 : (1 << (k % 4));
      if ($urandom_range(0, 3) != 0 && k != 3'd7) a = a & ~64'(sz - 1);
      run_load(k, a, rnd64(), $urandom_range(0, TMO + 2));
      // idle gap with stray acks
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        mem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("idle_req", 64'(mem_req), 64'd0);
        check("idle_done", 64'(done), 64'd0);
      end
      mem_ack = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
